// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx transmitter.
// Used by uart_tx and uart_sync_fifo.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_MIN_DIVISOR = 4;
    localparam int UART_DATA_BITS   = 8;

    // Bit periods shorter than the minimum are clamped up to it.
    function automatic logic [15:0] eff_divisor(input logic [15:0] divisor);
        return (divisor < 16'(UART_MIN_DIVISOR)) ? 16'(UART_MIN_DIVISOR) : divisor;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for the transmit byte queue.
// The head entry is presented combinationally on rdata; DEPTH must be a power of 2.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with transmit FIFO and back-to-back framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (0) for one bit period
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (1); may chain straight into the next START
module uart_tx
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            cfg_divisor,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   ser_tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    baud_q, baud_d;
    logic [15:0]    div_q, div_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           ser_d;
    logic           pop;
    logic           load;
    logic           bit_end;
    logic [15:0]    eff_div;
    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif

    assign tx_ready = !fifo_full && !reset;
    assign busy     = (state_q != IDLE) || (fifo_level != '0);
    assign eff_div  = eff_divisor(cfg_divisor);
    assign bit_end  = (baud_q == 16'd0);

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid && tx_ready),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ser_d   = ser_tx;
        pop     = 1'b0;
        load    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                ser_d = 1'b1;
                load  = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = div_q - 16'd1;
                    bit_d   = 3'd0;
                    ser_d   = shift_q[0];
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = div_q - 16'd1;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        ser_d   = par_q;
`else
                        state_d = STOP;
                        ser_d   = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        ser_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    baud_d  = div_q - 16'd1;
                    ser_d   = 1'b1;
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    ser_d   = 1'b1;
                    load    = !fifo_empty;
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ser_d   = 1'b1;
            end
        endcase

        // Frame start: the divisor is sampled here only, so mid-frame changes wait a frame.
        if (load) begin
            pop     = 1'b1;
            state_d = START;
            ser_d   = 1'b0;
            div_d   = eff_div;
            baud_d  = eff_div - 16'd1;
            shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            div_q   <= 16'(UART_MIN_DIVISOR);
            bit_q   <= '0;
            shift_q <= '0;
            ser_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ser_tx  <= ser_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor decodes ser_tx.
// Parity checks are compiled in when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cfg_divisor = 16'd8;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        ser_tx;
    logic        busy;
    logic [3:0]  fifo_level;

    uart_tx #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_divisor (cfg_divisor),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ser_tx      (ser_tx),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         start;
        bit         contig;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   frames_exp = 0;
    int   frames_done = 0;
    bit   mon_abort = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic exp_bit(input exp_t e, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return e.data[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^e.data;
`endif
        return 1'b1;
    endfunction

    // Monitor: check every cycle of each frame against the expected waveform.
    int   m_s;
    int   m_last_end = -1;
    bit   m_bad;
    bit   m_aborted;
    exp_t m_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_abort && !reset && ser_tx === 1'b0) begin
                m_s = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with empty scoreboard", m_s);
                    while (ser_tx === 1'b0) @(negedge clk);
                end else begin
                    m_e = exp_q.pop_front();
                    m_bad = 1'b0;
                    m_aborted = 1'b0;
                    for (int i = 0; i < NB * m_e.div; i++) begin
                        if (i > 0) @(negedge clk);
                        if (mon_abort || reset) begin
                            m_aborted = 1'b1;
                            break;
                        end
                        if (ser_tx !== exp_bit(m_e, i / m_e.div)) m_bad = 1'b1;
                    end
                    if (!m_aborted) begin
                        checks++;
                        if (m_bad) begin
                            errors++;
                            $display("FAIL frame_waveform: byte 0x%02h div %0d started cycle %0d got a wrong bit", m_e.data, m_e.div, m_s);
                        end
                        if (m_e.start >= 0) check("frame_start_cycle", m_s, m_e.start);
                        if (m_e.contig) check("frame_contiguous", m_s, m_last_end);
                        m_last_end = m_s + NB * m_e.div;
                        frames_done++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int div, input bit chk_start,
                        input bit contig, output int edge_n);
        exp_t e;
        int   g;
        g = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tx_ready got 0 expected 1 for byte 0x%02h", b);
            edge_n = -1;
            return;
        end
        edge_n   = cyc + 1;
        e.data   = b;
        e.div    = div;
        e.start  = chk_start ? edge_n + 1 : -1;
        e.contig = contig;
        exp_q.push_back(e);
        frames_exp++;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy got 1 expected 0");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e3, e4;
        int ed[10];
        logic [7:0] burst[10];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ser_tx", ser_tx, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_level", fifo_level, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_tx_ready", tx_ready, 1);

        // Single 0x55 frame at divisor 8
        cfg_divisor = 16'd8;
        send(8'h55, 8, 1'b1, 1'b0, e0);
        tx_valid = 1'b0;
        check("t1_level_after_push", fifo_level, 1);
        check("t1_ser_idle_before_pop", ser_tx, 1);
        @(negedge clk);
        check("t1_ser_start", ser_tx, 0);
        check("t1_level_after_pop", fifo_level, 0);
        check("t1_busy_in_frame", busy, 1);
        wait_cyc(e0 + 80);
        check("t1_busy_last_stop_cycle", busy, 1);
        @(negedge clk);
        check("t1_busy_drop_edge81", busy, 0);
        check("t1_ser_idle_after", ser_tx, 1);
        wait_idle();

        // Burst of 10 bytes with tx_valid held high
        for (int i = 0; i < 10; i++) begin
            send(burst[i], 8, 1'b0, i > 0, ed[i]);
            if (i == 8) begin
                check("t2_level_full", fifo_level, 8);
                check("t2_ready_low_when_full", tx_ready, 0);
            end
        end
        tx_valid = 1'b0;
        check("t2_ninth_accept_edge", ed[8] - ed[0], 8);
        check("t2_tenth_accept_edge", ed[9] - ed[0], 82);
        wait_idle();

        // Divisor clamp and mid-frame divisor change
        cfg_divisor = 16'd2;
        send(8'h3C, 4, 1'b1, 1'b0, e0);
        tx_valid = 1'b0;
        wait_cyc(e0 + 40);
        check("t3_busy_clamped_last", busy, 1);
        @(negedge clk);
        check("t3_busy_clamped_40", busy, 0);
        wait_idle();
        cfg_divisor = 16'd8;
        send(8'h81, 8, 1'b1, 1'b0, e0);
        send(8'h42, 16, 1'b0, 1'b1, e1);
        tx_valid = 1'b0;
        wait_cyc(e0 + 20);
        cfg_divisor = 16'd16;
        wait_idle();

        // Reset during data bit 3 of 0xA3
        cfg_divisor = 16'd8;
        send(8'hA3, 8, 1'b1, 1'b0, e0);
        tx_valid = 1'b0;
        wait_cyc(e0 + 34);
        mon_abort = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t4_ready_in_reset", tx_ready, 0);
        @(negedge clk);
        check("t4_ser_after_reset", ser_tx, 1);
        check("t4_level_after_reset", fifo_level, 0);
        check("t4_busy_after_reset", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("t4_ready_after_release", tx_ready, 1);
        exp_q.delete();
        frames_exp--;
        mon_abort = 1'b0;
        send(8'hC5, 8, 1'b1, 1'b0, e0);
        tx_valid = 1'b0;
        wait_idle();

`ifdef UART_TX_PARITY_EN
        // Even parity at divisor 4
        cfg_divisor = 16'd4;
        send(8'h07, 4, 1'b1, 1'b0, e0);
        tx_valid = 1'b0;
        wait_cyc(e0 + 38);
        check("t5_parity_07", ser_tx, 1);
        wait_cyc(e0 + 44);
        check("t5_busy_last_44", busy, 1);
        @(negedge clk);
        check("t5_busy_drop_44", busy, 0);
        wait_idle();
        send(8'h03, 4, 1'b1, 1'b0, e0);
        tx_valid = 1'b0;
        wait_cyc(e0 + 38);
        check("t5_parity_03", ser_tx, 0);
        wait_idle();
`endif

        // Push and pop together at the STOP->START boundary with 3 queued
        cfg_divisor = 16'd4;
        send(8'h5A, 4, 1'b1, 1'b0, e0);
        send(8'hA5, 4, 1'b0, 1'b1, e1);
        send(8'h0F, 4, 1'b0, 1'b1, e1);
        send(8'hF0, 4, 1'b0, 1'b1, e3);
        tx_valid = 1'b0;
        check("t6_fourth_push_edge", e3 - e0, 3);
        wait_cyc(e0 + 40);
        check("t6_level_before_boundary", fifo_level, 3);
        send(8'hE7, 4, 1'b0, 1'b1, e4);
        tx_valid = 1'b0;
        check("t6_push_at_boundary", e4 - e0, 41);
        check("t6_level_after_boundary", fifo_level, 3);
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        check("frames_completed", frames_done, frames_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
